// File: rtl/avalon_sdram_arbiter.sv
// Two-port round-robin Avalon-MM arbiter in front of the SDRAM controller.
// A tag FIFO records the owner of each accepted read so returning data is routed to that port.
module avalon_sdram_arbiter #(
  parameter int unsigned AW              = 24,
  parameter int unsigned DW              = 16,
  parameter int unsigned BYTE            = 2,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            s0_read,
  input  logic            s0_write,
  input  logic [AW-1:0]   s0_address,
  input  logic [DW-1:0]   s0_writedata,
  input  logic [BYTE-1:0] s0_byteenable,
  output logic            s0_waitrequest,
  output logic [DW-1:0]   s0_readdata,
  output logic            s0_readdatavalid,

  input  logic            s1_read,
  input  logic            s1_write,
  input  logic [AW-1:0]   s1_address,
  input  logic [DW-1:0]   s1_writedata,
  input  logic [BYTE-1:0] s1_byteenable,
  output logic            s1_waitrequest,
  output logic [DW-1:0]   s1_readdata,
  output logic            s1_readdatavalid,

  output logic            m_read,
  output logic            m_write,
  output logic [AW-1:0]   m_address,
  output logic [DW-1:0]   m_writedata,
  output logic [BYTE-1:0] m_byteenable,
  input  logic            m_waitrequest,
  input  logic [DW-1:0]   m_readdata,
  input  logic            m_readdatavalid,

  output logic            stray_rdv
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic                       last_grant;
  logic                       gnt_valid;
  logic                       gnt_id;
  logic                       elig0;
  logic                       elig1;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic                       head_id;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;

  // Full is judged on the registered count only; a same-cycle pop never unblocks a read.
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign elig0      = s0_write | (s0_read & ~fifo_full);
  assign elig1      = s1_write | (s1_read & ~fifo_full);

  always_comb begin
    gnt_valid = elig0 | elig1;
    gnt_id    = 1'b0;
    if (elig0 & elig1) begin
      gnt_id = ~last_grant;
    end else if (elig1) begin
      gnt_id = 1'b1;
    end
  end

  // A write on the same port as a read takes precedence; the read is dropped.
  always_comb begin
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_writedata  = '0;
    m_byteenable = '0;
    if (gnt_valid) begin
      if (gnt_id) begin
        m_read       = s1_read & ~s1_write;
        m_write      = s1_write;
        m_address    = s1_address;
        m_writedata  = s1_writedata;
        m_byteenable = s1_byteenable;
      end else begin
        m_read       = s0_read & ~s0_write;
        m_write      = s0_write;
        m_address    = s0_address;
        m_writedata  = s0_writedata;
        m_byteenable = s0_byteenable;
      end
    end
  end

  assign accept = gnt_valid & ~m_waitrequest;
  assign push   = accept & m_read;
  assign pop    = m_readdatavalid & ~fifo_empty;

  assign s0_waitrequest = ~(gnt_valid & ~gnt_id & ~m_waitrequest);
  assign s1_waitrequest = ~(gnt_valid &  gnt_id & ~m_waitrequest);

  assign head_id          = tag_mem[rd_ptr];
  assign s0_readdatavalid = pop & ~head_id;
  assign s1_readdatavalid = pop &  head_id;
  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stray_rdv  <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= gnt_id;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_readdatavalid & fifo_empty) begin
        stray_rdv <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt_id;
    end
  end

endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
// Self-checking bench for avalon_sdram_arbiter: controller model plus read-owner scoreboard.
module tb_avalon_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [23:0] s0_address, s1_address;
  logic [15:0] s0_writedata, s1_writedata;
  logic [1:0]  s0_byteenable, s1_byteenable;
  logic        s0_waitrequest, s1_waitrequest;
  logic [15:0] s0_readdata, s1_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic        m_read, m_write;
  logic [23:0] m_address;
  logic [15:0] m_writedata;
  logic [1:0]  m_byteenable;
  logic        m_waitrequest;
  logic [15:0] m_readdata;
  logic        m_readdatavalid;
  logic        stray_rdv;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [15:0] mem    [0:255];
  logic [15:0] shadow [0:255];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rdv0_cnt = 0;
  int          rdv1_cnt = 0;
  bit          hold = 1'b0;
  bit          stray_req = 1'b0;

  avalon_sdram_arbiter #(
    .AW(24), .DW(16), .BYTE(2), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .stray_rdv(stray_rdv)
  );

  always #5 clk = ~clk;

  // In-order SDRAM controller: captures accepted transfers mid-cycle, returns read data after lat cycles.
  initial begin : ctrl_model
    logic       acc_rd, acc_wr, rst_s, do_rdv;
    logic [7:0] a;
    logic [15:0] wd, rd_d;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    rd_d            = '0;
    forever begin
      @(negedge clk);
      rst_s  = reset;
      acc_rd = m_read && !m_waitrequest;
      acc_wr = m_write && !m_waitrequest;
      a      = m_address[7:0];
      wd     = m_writedata;
      @(posedge clk);
      cyc++;
      do_rdv = 1'b0;
      if (rst_s) begin
        pend_q.delete();
      end else begin
        if (acc_wr) mem[a] = wd;
        if (acc_rd) pend_q.push_back('{data: mem[a], due: cyc + lat - 1});
      end
      if (stray_req) begin
        do_rdv    = 1'b1;
        rd_d      = 16'hDEAD;
        stray_req = 1'b0;
      end else if (!rst_s && !hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        do_rdv = 1'b1;
        rd_d   = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      #1;
      m_readdatavalid = do_rdv;
      if (do_rdv) m_readdata = rd_d;
    end
  end

  initial begin : rdv_checker
    exp_t        e;
    logic        got_port;
    logic [15:0] got_data;
    forever begin
      @(negedge clk);
      if (s0_readdatavalid === 1'b1 || s1_readdatavalid === 1'b1) begin
        tests++;
        if (s0_readdatavalid) rdv0_cnt++;
        if (s1_readdatavalid) rdv1_cnt++;
        got_port = s1_readdatavalid;
        got_data = got_port ? s1_readdata : s0_readdata;
        if (s0_readdatavalid && s1_readdatavalid) begin
          fails++;
          $display("FAIL rdv_both: s0_rdv=%b s1_rdv=%b, required only one", s0_readdatavalid, s1_readdatavalid);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rdv_unexpected: port %0d got data %h, required no readdatavalid", got_port, got_data);
        end else begin
          e = exp_q.pop_front();
          if (got_port !== e.port || got_data !== e.data) begin
            fails++;
            $display("FAIL rdv_route: port %0d data %h, required port %0d data %h", got_port, got_data, e.port, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s0_read = 1'b0; s0_write = 1'b0; s0_address = '0; s0_writedata = '0; s0_byteenable = 2'b11;
    s1_read = 1'b0; s1_write = 1'b0; s1_address = '0; s1_writedata = '0; s1_byteenable = 2'b11;
    m_waitrequest = 1'b0;
    hold = 1'b0;
    stray_req = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d reads still outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || m_address !== 24'h0 || s0_waitrequest !== 1'b1 ||
        s1_waitrequest !== 1'b1 || stray_rdv !== 1'b0 || s0_readdatavalid !== 1'b0 ||
        s1_readdatavalid !== 1'b0 || dut.count !== 4'd0 || dut.last_grant !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: m_read=%b m_write=%b addr=%h w0=%b w1=%b stray=%b rdv=%b%b count=%0d lg=%b, required 0 0 000000 1 1 0 00 0 1",
               m_read, m_write, m_address, s0_waitrequest, s1_waitrequest, stray_rdv,
               s0_readdatavalid, s1_readdatavalid, dut.count, dut.last_grant);
    end
    tick();
  endtask

  task automatic test_single_port();
    do_reset();
    lat = 3;
    rdv0_cnt = 0;
    rdv1_cnt = 0;
    s0_write = 1'b1; s0_address = 24'h10; s0_writedata = 16'hA5A5;
    @(negedge clk);
    tests++;
    if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 24'h10 || m_writedata !== 16'hA5A5 ||
        m_byteenable !== 2'b11 || s0_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL single_write: m_write=%b m_read=%b addr=%h wdata=%h be=%b w0=%b, required 1 0 000010 a5a5 11 0",
               m_write, m_read, m_address, m_writedata, m_byteenable, s0_waitrequest);
    end
    shadow[8'h10] = 16'hA5A5;
    tick();
    s0_write = 1'b0; s0_read = 1'b1;
    @(negedge clk);
    tests++;
    if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 24'h10 || s0_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL single_read: m_read=%b m_write=%b addr=%h w0=%b, required 1 0 000010 0",
               m_read, m_write, m_address, s0_waitrequest);
    end
    exp_q.push_back('{port: 1'b0, data: shadow[8'h10]});
    tick();
    s0_read = 1'b0;
    @(negedge clk);
    tests++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || s0_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL single_idle: m_read=%b m_write=%b w0=%b, required 0 0 1", m_read, m_write, s0_waitrequest);
    end
    drain("single_drain");
    tests++;
    if (rdv0_cnt !== 1 || rdv1_cnt !== 0) begin
      fails++;
      $display("FAIL single_rdv_count: s0=%0d s1=%0d, required 1 0", rdv0_cnt, rdv1_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic exp_port;
    do_reset();
    lat = 2;
    s0_read = 1'b1; s0_address = 24'h20;
    s1_read = 1'b1; s1_address = 24'h30;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_port = k[0];
      tests++;
      if (s0_waitrequest !== exp_port || s1_waitrequest !== ~exp_port ||
          m_address !== (exp_port ? 24'h30 : 24'h20)) begin
        fails++;
        $display("FAIL rr_grant_%0d: w0=%b w1=%b addr=%h, required grant to port %0d",
                 k, s0_waitrequest, s1_waitrequest, m_address, exp_port);
      end
      exp_q.push_back('{port: exp_port, data: exp_port ? shadow[8'h30] : shadow[8'h20]});
      tick();
    end
    s0_read = 1'b0;
    s1_read = 1'b0;
    drain("rr_drain");
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1;
    s0_read = 1'b1; s0_address = 24'h40;
    s1_write = 1'b1; s1_address = 24'h41; s1_writedata = 16'h5A5A;
    m_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b1 || m_read !== 1'b1 ||
          m_address !== 24'h40 || dut.count !== 4'd0 || dut.last_grant !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_%0d: w0=%b w1=%b m_read=%b addr=%h count=%0d lg=%b, required 1 1 1 000040 0 1",
                 k, s0_waitrequest, s1_waitrequest, m_read, m_address, dut.count, dut.last_grant);
      end
      tick();
    end
    m_waitrequest = 1'b0;
    @(negedge clk);
    tests++;
    if (s0_waitrequest !== 1'b0 || s1_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: w0=%b w1=%b, required 0 1", s0_waitrequest, s1_waitrequest);
    end
    exp_q.push_back('{port: 1'b0, data: shadow[8'h40]});
    tick();
    s0_read = 1'b0;
    @(negedge clk);
    tests++;
    if (s1_waitrequest !== 1'b0 || m_write !== 1'b1 || m_writedata !== 16'h5A5A || m_address !== 24'h41) begin
      fails++;
      $display("FAIL bp_second: w1=%b m_write=%b wdata=%h addr=%h, required 0 1 5a5a 000041",
               s1_waitrequest, m_write, m_writedata, m_address);
    end
    shadow[8'h41] = 16'h5A5A;
    tick();
    s1_write = 1'b0;
    drain("bp_drain");
  endtask

  task automatic test_fifo_full();
    logic [7:0] a;
    do_reset();
    lat = 1;
    hold = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 8'h50 + 8'(k);
      s0_read = 1'b1; s0_address = {16'h0, a};
      @(negedge clk);
      tests++;
      if (s0_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL full_fill_%0d: w0=%b, required 0", k, s0_waitrequest);
      end
      exp_q.push_back('{port: 1'b0, data: shadow[a]});
      tick();
    end
    s0_address = 24'h58;
    s1_write = 1'b1; s1_address = 24'h60; s1_writedata = 16'h1234;
    @(negedge clk);
    tests++;
    if (s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b0 || m_write !== 1'b1 || m_read !== 1'b0 || dut.count !== 4'd8) begin
      fails++;
      $display("FAIL full_stall: w0=%b w1=%b m_write=%b m_read=%b count=%0d, required 1 0 1 0 8",
               s0_waitrequest, s1_waitrequest, m_write, m_read, dut.count);
    end
    shadow[8'h60] = 16'h1234;
    tick();
    s1_write = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    tests++;
    if (s0_waitrequest !== 1'b1 || m_read !== 1'b0) begin
      fails++;
      $display("FAIL full_still: w0=%b m_read=%b, required 1 0", s0_waitrequest, m_read);
    end
    tick();
    @(negedge clk);
    tests++;
    if (m_readdatavalid !== 1'b1 || s0_waitrequest !== 1'b1 || m_read !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_cycle: m_rdv=%b w0=%b m_read=%b, required 1 1 0", m_readdatavalid, s0_waitrequest, m_read);
    end
    tick();
    @(negedge clk);
    tests++;
    if (s0_waitrequest !== 1'b0 || m_read !== 1'b1 || m_address !== 24'h58) begin
      fails++;
      $display("FAIL full_unblock: w0=%b m_read=%b addr=%h, required 0 1 000058", s0_waitrequest, m_read, m_address);
    end
    exp_q.push_back('{port: 1'b0, data: shadow[8'h58]});
    tick();
    s0_read = 1'b0;
    drain("full_drain");
  endtask

  task automatic test_push_pop();
    logic [7:0] a;
    do_reset();
    lat = 1;
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a = 8'h70 + 8'(k);
      s1_read = 1'b1; s1_address = {16'h0, a};
      @(negedge clk);
      tests++;
      if (s1_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL pp_fill_%0d: w1=%b, required 0", k, s1_waitrequest);
      end
      exp_q.push_back('{port: 1'b1, data: shadow[a]});
      tick();
    end
    s1_read = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.count !== 4'd5 || m_readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL pp_pre: count=%0d m_rdv=%b, required 5 0", dut.count, m_readdatavalid);
    end
    tick();
    s0_read = 1'b1; s0_address = 24'h7A;
    @(negedge clk);
    tests++;
    if (m_readdatavalid !== 1'b1 || s1_readdatavalid !== 1'b1 || s0_readdatavalid !== 1'b0 ||
        s0_waitrequest !== 1'b0 || s1_readdata !== shadow[8'h70]) begin
      fails++;
      $display("FAIL pp_same_cycle: m_rdv=%b rdv1=%b rdv0=%b w0=%b rd1=%h, required 1 1 0 0 %h",
               m_readdatavalid, s1_readdatavalid, s0_readdatavalid, s0_waitrequest, s1_readdata, shadow[8'h70]);
    end
    exp_q.push_back('{port: 1'b0, data: shadow[8'h7A]});
    tick();
    s0_read = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.count !== 4'd5) begin
      fails++;
      $display("FAIL pp_count: count=%0d, required 5", dut.count);
    end
    tick();
    drain("pp_drain");
  endtask

  task automatic test_stray_reset();
    do_reset();
    stray_req = 1'b1;
    @(negedge clk);
    tests++;
    if (stray_rdv !== 1'b0) begin
      fails++;
      $display("FAIL stray_before: stray=%b, required 0", stray_rdv);
    end
    tick();
    @(negedge clk);
    tests++;
    if (m_readdatavalid !== 1'b1 || s0_readdatavalid !== 1'b0 || s1_readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL stray_route: m_rdv=%b rdv0=%b rdv1=%b, required 1 0 0", m_readdatavalid, s0_readdatavalid, s1_readdatavalid);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (stray_rdv !== 1'b1) begin
        fails++;
        $display("FAIL stray_sticky_%0d: stray=%b, required 1", k, stray_rdv);
      end
      tick();
    end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s0_read = 1'b1; s0_address = 24'h80 + 24'(k);
      @(negedge clk);
      tests++;
      if (s0_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL rst_fill_%0d: w0=%b, required 0", k, s0_waitrequest);
      end
      tick();
    end
    s0_read = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.count !== 4'd3 || stray_rdv !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: count=%0d stray=%b, required 3 1", dut.count, stray_rdv);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.count !== 4'd0 || stray_rdv !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: count=%0d stray=%b, required 0 0", dut.count, stray_rdv);
    end
    hold = 1'b0;
    repeat (5) tick();
  endtask

  initial begin : main
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'h1000 + 16'(i);
      shadow[i] = 16'h1000 + 16'(i);
    end
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_push_pop();
    test_stray_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_sdram_arbiter.md
Name: avalon_sdram_arbiter

Overview:
Two-port Avalon-MM arbiter that sits directly upstream of the SDRAM controller's Avalon slave interface. It lets two masters (for example a CPU data port and a DMA/video engine) share one SDRAM controller. It arbitrates requests round-robin and forwards the winner to the controller. It records the owner of every accepted read in an in-order tag FIFO so that pipelined read data returns to the correct master.

Parameters:
AW, 24, Avalon word address width (equals controller AVS_AW)
DW, 16, Avalon data width (equals controller AVS_DW)
BYTE, 2, byteenable width (DW/8)
MAX_OUTSTANDING, 8, depth of read-owner tag FIFO; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
s0_read, s0_write  in  1  port 0 requests
s0_address  in  AW  port 0 address
s0_writedata  in  DW  port 0 write data
s0_byteenable  in  BYTE  port 0 byte enables
s0_waitrequest  out  1  port 0 stall
s0_readdata  out  DW  port 0 read data
s0_readdatavalid  out  1  port 0 read data valid
s1_*  same set as s0_*, for port 1
m_read, m_write  out  1  to controller
m_address  out  AW  to controller
m_writedata  out  DW  to controller
m_byteenable  out  BYTE  to controller
m_waitrequest  in  1  from controller
m_readdata  in  DW  from controller
m_readdatavalid  in  1  from controller
stray_rdv  out  1  sticky error: readdatavalid seen with no outstanding read

Behaviour:
- Request: port i requests when sI_read|sI_write. Read and write asserted together on a port is illegal; if it occurs, the write wins and the read is ignored.
- Eligibility: a read request is eligible only when the tag FIFO is not full. A write request is always eligible. The full check uses the registered count only; a same-cycle pop does not unblock a read.
- Grant: combinational. If exactly one port is eligible, it is granted. If both are eligible, the port that was not last_grant is granted.
- last_grant is a register. It updates to the granted port only on an accepted transfer, i.e. grant & ~m_waitrequest. With m_waitrequest high and requests unchanged, the grant is stable.
- Master side: m_* is a combinational mux of the granted port's signals. With no grant, m_read=m_write=0 and address/data/byteenable = 0.
- Slave waitrequest: sI_waitrequest = ~(grant==i & ~m_waitrequest). A non-granted requesting port is therefore stalled. With no request, waitrequest is 1 (Avalon-legal).
- Tag FIFO push: on an accepted read, push the granted port id (1 bit).
- Tag FIFO pop and routing: on m_readdatavalid with the FIFO non-empty, pop the head. The head's port gets sI_readdatavalid=1 in the same cycle (zero latency). s0_readdata and s1_readdata both carry m_readdata at all times.
- Simultaneous push and pop are legal in the same cycle; count is unchanged.
- Stray data: m_readdatavalid with the FIFO empty drives no readdatavalid and sets stray_rdv=1. stray_rdv holds until reset.
- Ordering: the controller returns reads in order, so the FIFO head always matches the returning data.
- Pointers: wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING)+1.
- Reset values: last_grant=1 (so port 0 wins the first tie), FIFO empty, count=0, stray_rdv=0. All outputs derive combinationally from these values and the inputs: readdatavalid=0, m_read=m_write=0 when idle.
- Reset mid-operation: outstanding tags are discarded. The controller shares the same reset, so no in-flight data returns after reset.
- Pure combinational path m_waitrequest -> sI_waitrequest is accepted; there are no extra pipeline stages.

Test Plan:
- Single port: s0 writes 0xA5A5 to addr 0x10, then reads addr 0x10 with controller latency 3 -> one m_write, one m_read; s0_readdatavalid pulses once with 0xA5A5; s1_readdatavalid stays 0.
- Tie round-robin: s0 and s1 both hold reads continuously with m_waitrequest=0 for 6 cycles after reset -> grant order 0,1,0,1,0,1; readdatavalid routed alternately in that order.
- Backpressure: both ports request and m_waitrequest=1 for 4 cycles -> grant stable on port 0; no FIFO push; last_grant unchanged; on release, port 0 is accepted first.
- FIFO full: MAX_OUTSTANDING=8; s0 issues 8 reads and the controller withholds data -> the 9th read is stalled while an s1 write is still accepted; the first m_readdatavalid pops and the read is accepted the following cycle.
- Simultaneous push/pop: a read is accepted in the same cycle as a returning readdatavalid at count=5 -> count stays 5 and data is routed to the head owner.
- Stray/reset: m_readdatavalid with the FIFO empty -> no sI_readdatavalid and stray_rdv=1 until reset. Reset asserted with 3 reads outstanding -> count=0 and stray_rdv=0 the next cycle.
